// File: rtl/tlul_host_arbiter.sv
// N-host to 1-device TileLink-UL arbiter with in-order response routing.
// Define TLUL_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.
module tlul_host_arbiter #(
  parameter  int N_HOSTS         = 2,
  parameter  int ADDR_W          = 12,
  parameter  int DATA_W          = 32,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int MASK_W          = DATA_W / 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_HOSTS-1:0]         h_a_valid_i,
  output logic [N_HOSTS-1:0]         h_a_ready_o,
  input  logic [N_HOSTS*3-1:0]       h_a_opcode_i,
  input  logic [N_HOSTS*ADDR_W-1:0]  h_a_address_i,
  input  logic [N_HOSTS*DATA_W-1:0]  h_a_data_i,
  input  logic [N_HOSTS*2-1:0]       h_a_size_i,
  input  logic [N_HOSTS*MASK_W-1:0]  h_a_mask_i,
  output logic                       dev_a_valid_o,
  input  logic                       dev_a_ready_i,
  output logic [2:0]                 dev_a_opcode_o,
  output logic [ADDR_W-1:0]          dev_a_address_o,
  output logic [DATA_W-1:0]          dev_a_data_o,
  output logic [1:0]                 dev_a_size_o,
  output logic [MASK_W-1:0]          dev_a_mask_o,
  input  logic                       dev_d_valid_i,
  output logic                       dev_d_ready_o,
  input  logic [2:0]                 dev_d_opcode_i,
  input  logic [1:0]                 dev_d_size_i,
  input  logic [DATA_W-1:0]          dev_d_data_i,
  output logic [N_HOSTS-1:0]         h_d_valid_o,
  input  logic [N_HOSTS-1:0]         h_d_ready_i,
  output logic [N_HOSTS*3-1:0]       h_d_opcode_o,
  output logic [N_HOSTS*2-1:0]       h_d_size_o,
  output logic [N_HOSTS*DATA_W-1:0]  h_d_data_o,
  output logic                       orphan_err_o
);

  localparam int GW = (N_HOSTS > 1) ? $clog2(N_HOSTS) : 1;
  localparam int PW = $clog2(MAX_OUTSTANDING);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state, state_d;
  logic [GW-1:0] grant, grant_d, pick;
  logic [GW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic [GW-1:0] head;
  logic          full, empty, push, pop;

  assign full  = (count == (PW+1)'(MAX_OUTSTANDING));
  assign empty = (count == '0);
  assign head  = fifo_q[rd_ptr];

`ifdef TLUL_ARB_FIXED_PRIO_EN
  always_comb begin
    pick = '0;
    for (int i = N_HOSTS - 1; i >= 0; i--) begin
      if (h_a_valid_i[i]) pick = GW'(i);
    end
  end
`else
  logic [GW-1:0] rr_ptr;
  logic          found;
  int            idx;

  // Cyclic search starting at rr_ptr; first hit wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_HOSTS; i++) begin
      idx = (int'(rr_ptr) + i) % N_HOSTS;
      if (!found && h_a_valid_i[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (grant == GW'(N_HOSTS - 1)) ? '0 : grant + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
    end else begin
      state <= state_d;
      grant <= grant_d;
    end
  end

  always_comb begin
    state_d         = state;
    grant_d         = grant;
    push            = 1'b0;
    dev_a_valid_o   = 1'b0;
    h_a_ready_o     = '0;
    dev_a_opcode_o  = '0;
    dev_a_address_o = '0;
    dev_a_data_o    = '0;
    dev_a_size_o    = '0;
    dev_a_mask_o    = '0;
    unique case (state)
      IDLE: begin
        if (|h_a_valid_i && !full) begin
          state_d = SEND;
          grant_d = pick;
        end
      end
      SEND: begin
        dev_a_valid_o      = 1'b1;
        dev_a_opcode_o     = h_a_opcode_i[int'(grant)*3 +: 3];
        dev_a_address_o    = h_a_address_i[int'(grant)*ADDR_W +: ADDR_W];
        dev_a_data_o       = h_a_data_i[int'(grant)*DATA_W +: DATA_W];
        dev_a_size_o       = h_a_size_i[int'(grant)*2 +: 2];
        dev_a_mask_o       = h_a_mask_i[int'(grant)*MASK_W +: MASK_W];
        h_a_ready_o[grant] = dev_a_ready_i;
        if (dev_a_ready_i) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Responses with nothing outstanding are swallowed so the device never stalls.
  always_comb begin
    h_d_valid_o = '0;
    if (!empty) h_d_valid_o[head] = dev_d_valid_i;
    dev_d_ready_o = empty ? dev_d_valid_i : h_d_ready_i[head];
    pop = dev_d_valid_i && !empty && h_d_ready_i[head];
  end

  assign h_d_opcode_o = {N_HOSTS{dev_d_opcode_i}};
  assign h_d_size_o   = {N_HOSTS{dev_d_size_i}};
  assign h_d_data_o   = {N_HOSTS{dev_d_data_i}};

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= grant;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      orphan_err_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (dev_d_valid_i && empty) orphan_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tlul_host_arbiter.sv
// Randomized self-checking bench for tlul_host_arbiter (2 hosts).
// Transaction-level reference model: grant rule, outstanding queue, orphan flag.
module tb_tlul_host_arbiter;

  localparam int N = 2;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int MAXO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  h_a_valid_i, h_a_ready_o;
  logic [N*3-1:0]  h_a_opcode_i;
  logic [N*AW-1:0] h_a_address_i;
  logic [N*DW-1:0] h_a_data_i;
  logic [N*2-1:0]  h_a_size_i;
  logic [N*MW-1:0] h_a_mask_i;
  logic          dev_a_valid_o, dev_a_ready_i;
  logic [2:0]    dev_a_opcode_o;
  logic [AW-1:0] dev_a_address_o;
  logic [DW-1:0] dev_a_data_o;
  logic [1:0]    dev_a_size_o;
  logic [MW-1:0] dev_a_mask_o;
  logic          dev_d_valid_i, dev_d_ready_o;
  logic [2:0]    dev_d_opcode_i;
  logic [1:0]    dev_d_size_i;
  logic [DW-1:0] dev_d_data_i;
  logic [N-1:0]  h_d_valid_o, h_d_ready_i;
  logic [N*3-1:0]  h_d_opcode_o;
  logic [N*2-1:0]  h_d_size_o;
  logic [N*DW-1:0] h_d_data_o;
  logic          orphan_err_o;

  always #5 clk = ~clk;

  tlul_host_arbiter #(
    .N_HOSTS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset(reset),
    .h_a_valid_i(h_a_valid_i), .h_a_ready_o(h_a_ready_o),
    .h_a_opcode_i(h_a_opcode_i), .h_a_address_i(h_a_address_i),
    .h_a_data_i(h_a_data_i), .h_a_size_i(h_a_size_i),
    .h_a_mask_i(h_a_mask_i),
    .dev_a_valid_o(dev_a_valid_o), .dev_a_ready_i(dev_a_ready_i),
    .dev_a_opcode_o(dev_a_opcode_o), .dev_a_address_o(dev_a_address_o),
    .dev_a_data_o(dev_a_data_o), .dev_a_size_o(dev_a_size_o),
    .dev_a_mask_o(dev_a_mask_o),
    .dev_d_valid_i(dev_d_valid_i), .dev_d_ready_o(dev_d_ready_o),
    .dev_d_opcode_i(dev_d_opcode_i), .dev_d_size_i(dev_d_size_i),
    .dev_d_data_i(dev_d_data_i),
    .h_d_valid_o(h_d_valid_o), .h_d_ready_i(h_d_ready_i),
    .h_d_opcode_o(h_d_opcode_o), .h_d_size_o(h_d_size_o),
    .h_d_data_o(h_d_data_o), .orphan_err_o(orphan_err_o)
  );

  int checks = 0;
  int failures = 0;
  bit m_send;
  int m_grant, m_rr;
  bit m_orphan;
  int q[$];
  int grant_log[$];
  int acc_cnt;
  logic [N-1:0] acc_mask;
  bit pend[N];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(logic [N-1:0] v, int rr);
`ifdef TLUL_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int i = 0; i < N; i++) if (v[(rr + i) % N]) return (rr + i) % N;
`endif
    return 0;
  endfunction

  task automatic settle();
    logic [N-1:0] er, ed;
    #1;
    er = '0;
    ed = '0;
    if (m_send) er[m_grant] = dev_a_ready_i;
    if (q.size() > 0) ed[q[0]] = dev_d_valid_i;
    chk("a_valid", dev_a_valid_o, m_send);
    chk("a_ready", h_a_ready_o, er);
    if (m_send) begin
      chk("a_op", dev_a_opcode_o, h_a_opcode_i[m_grant*3 +: 3]);
      chk("a_addr", dev_a_address_o, h_a_address_i[m_grant*AW +: AW]);
      chk("a_data", dev_a_data_o, h_a_data_i[m_grant*DW +: DW]);
      chk("a_size", dev_a_size_o, h_a_size_i[m_grant*2 +: 2]);
      chk("a_mask", dev_a_mask_o, h_a_mask_i[m_grant*MW +: MW]);
    end
    chk("d_valid", h_d_valid_o, ed);
    chk("d_ready", dev_d_ready_o,
        (q.size() > 0) ? h_d_ready_i[q[0]] : dev_d_valid_i);
    chk("d_data1", h_d_data_o[DW +: DW], dev_d_data_i);
    chk("orphan", orphan_err_o, m_orphan);
  endtask

  task automatic adv();
    int sz;
    bit popd;
    sz = q.size();
    popd = dev_d_valid_i && sz > 0 && h_d_ready_i[q[0]];
    acc_mask = '0;
    if (reset) begin
      m_send = 0;
      m_rr = 0;
      m_orphan = 0;
      q.delete();
    end else begin
      if (dev_d_valid_i && sz == 0) m_orphan = 1;
      if (popd) void'(q.pop_front());
      if (m_send) begin
        if (dev_a_ready_i) begin
          q.push_back(m_grant);
          grant_log.push_back(m_grant);
          acc_mask[m_grant] = 1'b1;
          acc_cnt++;
`ifndef TLUL_ARB_FIXED_PRIO_EN
          m_rr = (m_grant + 1) % N;
`endif
          m_send = 0;
        end
      end else if (|h_a_valid_i && sz < MAXO) begin
        m_grant = pick(h_a_valid_i, m_rr);
        m_send = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic tick();
    settle();
    adv();
  endtask

  task automatic idle_inputs();
    h_a_valid_i = '0;
    dev_a_ready_i = 1'b0;
    dev_d_valid_i = 1'b0;
    h_d_ready_i = '0;
    dev_d_data_i = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    bit ok;
    reset = 1'b1;
    idle_inputs();
    h_a_opcode_i = '0;
    h_a_address_i = '0;
    h_a_data_i = '0;
    h_a_size_i = '0;
    h_a_mask_i = '0;
    dev_d_opcode_i = 3'd1;
    dev_d_size_i = 2'd2;
    m_send = 0; m_rr = 0; m_orphan = 0; m_grant = 0; acc_cnt = 0;
    repeat (2) @(negedge clk);
    do_reset();

    settle();
    chk("rst_a_valid", dev_a_valid_o, 0);
    chk("rst_a_ready", h_a_ready_o, 0);
    chk("rst_a_addr", dev_a_address_o, 0);
    chk("rst_d_ready", dev_d_ready_o, 0);
    chk("rst_orphan", orphan_err_o, 0);
    adv();

    // Single Get from host0
    h_a_opcode_i[2:0] = 3'd4;
    h_a_address_i[AW-1:0] = 12'h010;
    h_a_valid_i = 2'b01;
    dev_a_ready_i = 1'b1;
    tick();
    settle();
    chk("get_valid", dev_a_valid_o, 1);
    chk("get_addr", dev_a_address_o, 12'h010);
    chk("get_op", dev_a_opcode_o, 3'd4);
    adv();
    h_a_valid_i = '0;
    dev_d_valid_i = 1'b1;
    dev_d_data_i = 32'hDEADBEEF;
    h_d_ready_i = 2'b11;
    settle();
    chk("get_dvalid", h_d_valid_o, 2'b01);
    chk("get_ddata", h_d_data_o[DW-1:0], 32'hDEADBEEF);
    adv();
    dev_d_valid_i = 1'b0;

    // Continuous requests from both hosts
    do_reset();
    grant_log.delete();
    h_a_valid_i = 2'b11;
    dev_a_ready_i = 1'b1;
    h_d_ready_i = 2'b11;
    repeat (12) begin
      dev_d_valid_i = (q.size() > 0);
      tick();
    end
    chk("rr_count", grant_log.size() >= 4, 1);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
`ifdef TLUL_ARB_FIXED_PRIO_EN
      chk("rr_grant", grant_log[i], 0);
`else
      chk("rr_grant", grant_log[i], i % 2);
`endif
    end

    // FIFO full blocks the fifth grant until a response drains one
    do_reset();
    acc_cnt = 0;
    h_a_valid_i = 2'b01;
    dev_a_ready_i = 1'b1;
    for (int i = 0; i < 40 && acc_cnt < 4; i++) tick();
    chk("full_fill", acc_cnt, 4);
    repeat (3) begin
      settle();
      chk("full_rdy", h_a_ready_o, 0);
      chk("full_val", dev_a_valid_o, 0);
      adv();
    end
    dev_d_valid_i = 1'b1;
    h_d_ready_i = 2'b01;
    settle();
    chk("full_pop", dev_d_ready_o, 1);
    adv();
    dev_d_valid_i = 1'b0;
    settle();
    chk("pop_same", dev_a_valid_o, 0);
    adv();
    settle();
    chk("regrant", dev_a_valid_o, 1);
    adv();

    // Out-of-host-order issue, in-order routing
    do_reset();
    dev_a_ready_i = 1'b1;
    h_a_valid_i = 2'b10;
    tick();
    settle();
    chk("ord_acc1", h_a_ready_o, 2'b10);
    adv();
    h_a_valid_i = 2'b01;
    tick();
    settle();
    chk("ord_acc0", h_a_ready_o, 2'b01);
    adv();
    h_a_valid_i = '0;
    dev_d_valid_i = 1'b1;
    dev_d_data_i = 32'h11111111;
    h_d_ready_i = 2'b01;
    repeat (3) begin
      settle();
      chk("ord_stall", dev_d_ready_o, 0);
      chk("ord_r1v", h_d_valid_o, 2'b10);
      adv();
    end
    h_d_ready_i = 2'b11;
    settle();
    chk("ord_r1", h_d_valid_o, 2'b10);
    chk("ord_r1d", h_d_data_o[DW +: DW], 32'h11111111);
    adv();
    dev_d_data_i = 32'h22222222;
    settle();
    chk("ord_r0", h_d_valid_o, 2'b01);
    adv();
    dev_d_valid_i = 1'b0;

    // Orphan response
    dev_d_valid_i = 1'b1;
    settle();
    chk("orph_rdy", dev_d_ready_o, 1);
    chk("orph_hv", h_d_valid_o, 0);
    adv();
    dev_d_valid_i = 1'b0;
    repeat (3) tick();
    settle();
    chk("orph_sticky", orphan_err_o, 1);
    adv();
    do_reset();
    settle();
    chk("orph_clr", orphan_err_o, 0);
    adv();

    // Reset while SEND is stalled
    h_a_valid_i = 2'b01;
    dev_a_ready_i = 1'b0;
    tick();
    settle();
    chk("rs_send", dev_a_valid_o, 1);
    reset = 1'b1;
    adv();
    reset = 1'b0;
    h_a_valid_i = '0;
    dev_d_valid_i = 1'b1;
    settle();
    chk("rs_idle", dev_a_valid_o, 0);
    chk("rs_empty", dev_d_ready_o, 1);
    chk("rs_nohv", h_d_valid_o, 0);
    adv();
    do_reset();

    // Randomized traffic
    for (int k = 0; k < N; k++) pend[k] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(1) == 1) begin
          pend[k] = 1;
          h_a_opcode_i[k*3 +: 3] = ($urandom_range(2) == 0) ? 3'd0 : 3'd4;
          h_a_address_i[k*AW +: AW] = AW'($urandom);
          h_a_data_i[k*DW +: DW] = $urandom;
          h_a_size_i[k*2 +: 2] = 2'($urandom);
          h_a_mask_i[k*MW +: MW] = MW'($urandom);
        end
        h_a_valid_i[k] = pend[k];
      end
      dev_a_ready_i = ($urandom_range(3) != 0);
      ok = ($urandom_range(9) != 0) || (q.size() > 0);
      dev_d_valid_i = ok && ($urandom_range(1) == 1);
      h_d_ready_i = N'($urandom);
      dev_d_data_i = $urandom;
      dev_d_opcode_i = 3'($urandom);
      tick();
      for (int k = 0; k < N; k++) if (acc_mask[k]) pend[k] = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tlul_host_arbiter.md
Name: tlul_host_arbiter

Overview:
- Parametrised N-host to 1-device TileLink-UL arbiter.
- Lets the core's instruction-fetch and data channel_a ports, plus future hosts, share one memory adapter.
- Arbitrates channel A with a round-robin grant and tracks outstanding requests in an in-order FIFO of host indices.
- Routes each channel D response back to the host that issued the request.

Parameters:
- N_HOSTS, 2, number of upstream hosts (2..8).
- ADDR_W, 12, address width.
- DATA_W, 32, data width; MASK_W = DATA_W/8 is derived.
- MAX_OUTSTANDING, 4, depth of the response-routing FIFO (power of 2, ≥2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- h_a_valid_i  in  N_HOSTS  per-host channel A valid
- h_a_ready_o  out  N_HOSTS  per-host channel A ready
- h_a_opcode_i  in  N_HOSTS*3  flattened opcodes, host k at [3k+:3]
- h_a_address_i  in  N_HOSTS*ADDR_W  flattened addresses
- h_a_data_i  in  N_HOSTS*DATA_W  flattened write data
- h_a_size_i  in  N_HOSTS*2  flattened sizes
- h_a_mask_i  in  N_HOSTS*MASK_W  flattened byte masks
- dev_a_valid_o  out  1  device channel A valid
- dev_a_ready_i  in  1  device channel A ready
- dev_a_opcode_o / dev_a_address_o / dev_a_data_o / dev_a_size_o / dev_a_mask_o  out  3/ADDR_W/DATA_W/2/MASK_W  granted request fields
- dev_d_valid_i  in  1  device response valid
- dev_d_ready_o  out  1  device response ready
- dev_d_opcode_i / dev_d_size_i / dev_d_data_i  in  3/2/DATA_W  response fields
- h_d_valid_o  out  N_HOSTS  per-host response valid
- h_d_ready_i  in  N_HOSTS  per-host response ready
- h_d_opcode_o / h_d_size_o / h_d_data_o  out  N_HOSTS*3 / N_HOSTS*2 / N_HOSTS*DATA_W  response fields broadcast to every host slice
- orphan_err_o  out  1  sticky: a response arrived with no outstanding request

Behaviour:
- Reset (synchronous, active-high, takes effect at any time including mid-transfer):
  - state=IDLE, grant=0, rr_ptr=0, FIFO emptied, orphan_err_o=0.
  - All valid/ready outputs 0; data outputs 0.
- A-side FSM, two states:
  - IDLE:
    - If any h_a_valid_i and FIFO not full, register grant = first requesting host at or after rr_ptr (cyclic search) and go to SEND.
    - Otherwise stay in IDLE.
    - All h_a_ready_o=0 and dev_a_valid_o=0 in IDLE.
  - SEND:
    - dev_a_valid_o=1; dev_a_* fields = slice [grant] of the host fields.
    - h_a_ready_o[grant]=dev_a_ready_i; all other h_a_ready_o=0.
    - On handshake (dev_a_valid_o & dev_a_ready_i): push grant into FIFO, rr_ptr=(grant+1) mod N_HOSTS, return to IDLE.
    - Grant is locked until handshake; hosts must hold valid and fields stable while waiting.
- Latency and throughput:
  - Host valid to dev_a_valid_o: 1 cycle.
  - Maximum rate: 1 request per 2 cycles.
- FIFO full:
  - No new grant is taken in IDLE.
  - A pop in the same cycle does not unblock a grant that cycle; the grant is taken the next cycle.
- D side (combinational routing on the FIFO head h):
  - h_d_valid_o[h]=dev_d_valid_i when FIFO not empty; all other h_d_valid_o=0.
  - dev_d_ready_o=h_d_ready_i[h].
  - On D handshake, pop the FIFO.
- Simultaneous A push and D pop: both take effect; count is unchanged.
- FIFO empty while dev_d_valid_i=1:
  - dev_d_ready_o=1 (response is dropped).
  - All h_d_valid_o=0.
  - orphan_err_o is set and stays set until reset.
- Pointers wrap modulo MAX_OUTSTANDING. Count width is clog2(MAX_OUTSTANDING)+1.

Optional Feature:
- Macro: TLUL_ARB_FIXED_PRIO_EN.
- Defined: the grant in IDLE is the lowest-index requesting host; rr_ptr is neither used nor updated.
- Undefined: round-robin arbitration as above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then host0 Get at addr 0x010 → dev_a_valid_o=1 one cycle later with addr 0x010 and opcode 4; device acks with data 0xDEADBEEF → h_d_valid_o=2'b01, h_d_data_o slice 0 = 0xDEADBEEF.
- Both hosts request continuously, device always ready → grants alternate 0,1,0,1. With TLUL_ARB_FIXED_PRIO_EN defined → grants are always 0.
- Device never responds; 4 requests accepted → 5th request sees h_a_ready_o stay 0. One D response is then sent → the 5th request is granted the following cycle.
- Host1 request issued first, then host0 request; responses R1 then R0 → R1 is routed to host1 and R0 to host0. With h_d_ready_i[1]=0 for 3 cycles, dev_d_ready_o stays 0 for those 3 cycles.
- Inject dev_d_valid_i=1 with the FIFO empty → dev_d_ready_o=1, no h_d_valid_o asserted, orphan_err_o=1 and it holds until reset.
- Assert reset during SEND with dev_a_ready_i=0 → next cycle dev_a_valid_o=0, FIFO empty, state IDLE.
